// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB transfer controller:
// FSM state encoding, one-hot slave selects and the address decode field.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [2:0] SEL_S0   = 3'b001;
    localparam logic [2:0] SEL_S1   = 3'b010;
    localparam logic [2:0] SEL_S2   = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b000;

    localparam int DEC_HI = 27;
    localparam int DEC_LO = 26;

    // Field value 2'b11 has no slave behind it and maps to SEL_NONE.
    function automatic logic [2:0] decode_sel(input logic [1:0] field);
        logic [2:0] sel;
        case (field)
            2'b00:   sel = SEL_S0;
            2'b01:   sel = SEL_S1;
            2'b10:   sel = SEL_S2;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_transfer_ctrl_if.sv
// Bus bundle between the AHB-side requester / APB slave and the controller.
// 'slave' is the controller's view, 'master' is the environment's view.
interface apb_transfer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              Hwrite;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;
    logic              Hrvalid;

    logic              Pwrite;
    logic [2:0]        Pselx;
    logic              Penable;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic [DATA_W-1:0] Prdata;

    modport slave (
        input  valid, Hwrite, Haddr, Hwdata, Prdata,
        output Hreadyout, Hrdata, Hrvalid,
        output Pwrite, Pselx, Penable, Paddr, Pwdata
    );

    modport master (
        output valid, Hwrite, Haddr, Hwdata, Prdata,
        input  Hreadyout, Hrdata, Hrvalid,
        input  Pwrite, Pselx, Penable, Paddr, Pwdata
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational peripheral decode: address field -> one-hot select plus
// a flag telling whether any slave lives at that address.
module apb_addr_decode
    import apb_ctrl_pkg::*;
(
    input  logic [1:0] field,
    output logic [2:0] sel,
    output logic       mapped
);

    always_comb begin
        sel    = decode_sel(field);
        mapped = (sel != SEL_NONE);
    end

endmodule

// File: rtl/apb_transfer_ctrl.sv
// Sequences fixed two-cycle APB SETUP/ACCESS transfers from a one-entry
// pending buffer fed by the AHB side; read data is returned as Hrdata.
module apb_transfer_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                Hclk,
    input  logic                Hreset,
    apb_transfer_ctrl_if.slave  bus
);

    state_t            state;
    state_t            stateNext;

    logic              pendVld;
    logic              pendWrite;
    logic [ADDR_W-1:0] pendAddr;
    logic [DATA_W-1:0] pendWdata;
    logic [2:0]        pendSel;

    logic [2:0]        reqSel;
    logic              reqMapped;
    logic              accept;
    logic              loadPend;
    logic              captureRd;

    apb_addr_decode u_decode (
        .field  (bus.Haddr[DEC_HI:DEC_LO]),
        .sel    (reqSel),
        .mapped (reqMapped)
    );

    assign bus.Hreadyout = ~pendVld;
    assign accept        = bus.valid && ~pendVld;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Any edge leaving ACCESS completes a transfer; a waiting request is
    // loaded straight into SETUP so back-to-back transfers have no gap.
    always_comb begin
        stateNext = state;
        loadPend  = 1'b0;
        captureRd = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pendVld) begin
                    stateNext = ST_SETUP;
                    loadPend  = 1'b1;
                end
            end
            ST_SETUP: begin
                stateNext = ST_ACCESS;
            end
            ST_ACCESS: begin
                captureRd = ~bus.Pwrite;
                if (pendVld) begin
                    stateNext = ST_SETUP;
                    loadPend  = 1'b1;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Unmapped requests are accepted but never enter the buffer.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            pendVld   <= 1'b0;
            pendWrite <= 1'b0;
            pendAddr  <= '0;
            pendWdata <= '0;
            pendSel   <= SEL_NONE;
        end else if (accept && reqMapped) begin
            pendVld   <= 1'b1;
            pendWrite <= bus.Hwrite;
            pendAddr  <= bus.Haddr;
            pendWdata <= bus.Hwdata;
            pendSel   <= reqSel;
        end else if (loadPend) begin
            pendVld   <= 1'b0;
        end
    end

    // Paddr/Pwdata/Pwrite keep their last values while idle.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            bus.Pwrite  <= 1'b0;
            bus.Pselx   <= SEL_NONE;
            bus.Penable <= 1'b0;
            bus.Paddr   <= '0;
            bus.Pwdata  <= '0;
            bus.Hrdata  <= '0;
            bus.Hrvalid <= 1'b0;
        end else begin
            bus.Hrvalid <= captureRd;
            if (captureRd) begin
                bus.Hrdata <= bus.Prdata;
            end
            if (loadPend) begin
                bus.Pselx   <= pendSel;
                bus.Pwrite  <= pendWrite;
                bus.Paddr   <= pendAddr;
                bus.Pwdata  <= pendWdata;
                bus.Penable <= 1'b0;
            end else if (state == ST_SETUP) begin
                bus.Penable <= 1'b1;
            end else if (state == ST_ACCESS) begin
                bus.Pselx   <= SEL_NONE;
                bus.Penable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// Directed bench for apb_transfer_ctrl: a per-cycle vector table for single,
// back-to-back and unmapped transfers, plus a hand sequence for mid-transfer reset.
module tb_apb_transfer_ctrl;

    logic Hclk;
    logic Hreset;
    int   checks;
    int   errors;

    apb_transfer_ctrl_if bus ();

    apb_transfer_ctrl dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        valid;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic        rdy;
        logic [2:0]  sel;
        logic        en;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwr;
        logic        hrv;
        logic [31:0] hrdata;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] prd,
                                input logic rdy, input logic [2:0] sel, input logic en,
                                input logic [31:0] pa, input logic [31:0] pd,
                                input logic pw, input logic hrv, input logic [31:0] hrd);
        vec_t r;
        r.valid = v;   r.hwrite = w;  r.haddr = a;   r.hwdata = d; r.prdata = prd;
        r.rdy = rdy;   r.sel = sel;   r.en = en;     r.paddr = pa; r.pwdata = pd;
        r.pwr = pw;    r.hrv = hrv;   r.hrdata = hrd;
        return r;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int idx, input vec_t e);
        checkField({tag, ".Hreadyout"}, idx, {31'd0, bus.Hreadyout}, {31'd0, e.rdy});
        checkField({tag, ".Pselx"},     idx, {29'd0, bus.Pselx},     {29'd0, e.sel});
        checkField({tag, ".Penable"},   idx, {31'd0, bus.Penable},   {31'd0, e.en});
        checkField({tag, ".Paddr"},     idx, bus.Paddr,              e.paddr);
        checkField({tag, ".Pwdata"},    idx, bus.Pwdata,             e.pwdata);
        checkField({tag, ".Pwrite"},    idx, {31'd0, bus.Pwrite},    {31'd0, e.pwr});
        checkField({tag, ".Hrvalid"},   idx, {31'd0, bus.Hrvalid},   {31'd0, e.hrv});
        checkField({tag, ".Hrdata"},    idx, bus.Hrdata,             e.hrdata);
    endtask

    // Drive one cycle of inputs, take the rising edge, sample 1 time unit later.
    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] prd);
        bus.valid  = v;
        bus.Hwrite = w;
        bus.Haddr  = a;
        bus.Hwdata = d;
        bus.Prdata = prd;
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        vec_t e;
        checks = 0;
        errors = 0;

        //              v  w  haddr          hwdata         prdata          rdy sel     en paddr          pwdata         pw hrv hrdata
        // single write
        vecs[0]  = mk(1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,          0, 3'b000, 0, 32'h0,          32'h0,          0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b001, 0, 32'h8000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b001, 1, 32'h8000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b000, 0, 32'h8000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
        // single read, Hwdata still forwarded to Pwdata
        vecs[4]  = mk(1, 0, 32'h8800_0004, 32'h1234_5678, 32'h0,          0, 3'b000, 0, 32'h8000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b100, 0, 32'h8800_0004, 32'h1234_5678, 0, 0, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b100, 1, 32'h8800_0004, 32'h1234_5678, 0, 0, 32'h0);
        vecs[7]  = mk(0, 0, 32'h0,         32'h0,         32'd25,         1, 3'b000, 0, 32'h8800_0004, 32'h1234_5678, 0, 1, 32'd25);
        vecs[8]  = mk(0, 0, 32'h0,         32'h0,         32'd99,         1, 3'b000, 0, 32'h8800_0004, 32'h1234_5678, 0, 0, 32'd25);
        // back-to-back write then read, valid held high
        vecs[9]  = mk(1, 1, 32'h8400_0000, 32'hA5A5_0001, 32'h0,          0, 3'b000, 0, 32'h8800_0004, 32'h1234_5678, 0, 0, 32'd25);
        vecs[10] = mk(1, 0, 32'h8000_0008, 32'h0,         32'h0,          1, 3'b010, 0, 32'h8400_0000, 32'hA5A5_0001, 1, 0, 32'd25);
        vecs[11] = mk(1, 0, 32'h8000_0008, 32'h0,         32'h0,          0, 3'b010, 1, 32'h8400_0000, 32'hA5A5_0001, 1, 0, 32'd25);
        vecs[12] = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b001, 0, 32'h8000_0008, 32'h0,          0, 0, 32'd25);
        vecs[13] = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b001, 1, 32'h8000_0008, 32'h0,          0, 0, 32'd25);
        vecs[14] = mk(0, 0, 32'h0,         32'h0,         32'hCAFE_F00D,  1, 3'b000, 0, 32'h8000_0008, 32'h0,          0, 1, 32'hCAFE_F00D);
        // unmapped: accepted and dropped
        vecs[15] = mk(1, 1, 32'h8C00_0000, 32'h0000_FFFF, 32'h0,          1, 3'b000, 0, 32'h8000_0008, 32'h0,          0, 0, 32'hCAFE_F00D);
        vecs[16] = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b000, 0, 32'h8000_0008, 32'h0,          0, 0, 32'hCAFE_F00D);
        vecs[17] = mk(0, 0, 32'h0,         32'h0,         32'h0,          1, 3'b000, 0, 32'h8000_0008, 32'h0,          0, 0, 32'hCAFE_F00D);

        Hreset = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 32'h0);
        e = mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("reset", 0, e);
        Hreset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].hwrite, vecs[i].haddr,
                          vecs[i].hwdata, vecs[i].prdata);
            checkOutput("vec", i, vecs[i]);
        end

        // Mid-transfer reset with a second request pending behind the write.
        applyStimulus(1, 1, 32'h8000_0020, 32'h1111_1111, 32'h0);
        checkField("midrst.accept.Hreadyout", 0, {31'd0, bus.Hreadyout}, 32'd0);
        applyStimulus(1, 0, 32'h8400_0004, 32'h0, 32'h0);
        checkField("midrst.setup.Pselx", 1, {29'd0, bus.Pselx}, 32'd1);
        applyStimulus(1, 0, 32'h8400_0004, 32'h0, 32'h0);
        checkField("midrst.access.Penable", 2, {31'd0, bus.Penable}, 32'd1);
        checkField("midrst.access.Hreadyout", 2, {31'd0, bus.Hreadyout}, 32'd0);
        Hreset = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0, 32'h5555_5555);
        e = mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("midrst.edge", 3, e);
        applyStimulus(0, 0, 32'h0, 32'h0, 32'h5555_5555);
        Hreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'h0, 32'h0, 32'h5555_5555);
            checkOutput("midrst.after", 5 + i, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_transfer_ctrl.md
Name: apb_transfer_ctrl

Overview:
- Sequences APB SETUP and ACCESS phases for the AHB-to-APB bridge.
- Accepts single AHB-side requests through a one-entry pending buffer.
- Decodes the target peripheral into a one-hot Pselx and drives Pwrite/Pselx/Penable/Paddr/Pwdata into APB_Interface.
- Captures Prdata on read completion and returns it as Hrdata.
- Fixed two-cycle APB transfers; no Pready.

Parameters:
ADDR_W, 32, address width of Haddr/Paddr
DATA_W, 32, data width of Hwdata/Pwdata/Prdata/Hrdata

Ports:
Hclk  in  1  clock; all state updates on the rising edge
Hreset  in  1  synchronous, active-high reset
valid  in  1  AHB side presents a request this cycle
Hwrite  in  1  request direction: 1 = write, 0 = read
Haddr  in  ADDR_W  request address
Hwdata  in  DATA_W  write data (used only when Hwrite=1)
Hreadyout  out  1  controller can accept a request (combinational, equals ~pend_vld)
Hrdata  out  DATA_W  registered read data
Hrvalid  out  1  one-cycle pulse: Hrdata updated this cycle
Pwrite  out  1  APB direction
Pselx  out  3  one-hot APB slave select
Penable  out  1  APB enable (ACCESS phase)
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data

Behaviour:
- Reset, applied at the next rising edge while Hreset=1: state=ST_IDLE, pend_vld=0, and Pwrite, Pselx, Penable, Paddr, Pwdata, Hrdata, Hrvalid all become 0. Hreadyout is therefore 1.
- Reset mid-transfer: the in-flight transfer is abandoned and pending data is dropped. Pselx/Penable are 0 from the reset edge onward.
- Accept: a request is accepted at an edge where valid && Hreadyout. Its {Hwrite, Haddr, Hwdata, decoded sel} is latched into the pending register and pend_vld is set.
- Decode on Haddr[27:26]:
  - 00 -> 3'b001
  - 01 -> 3'b010
  - 10 -> 3'b100
  - 11 -> unmapped
- Unmapped requests are accepted and discarded. pend_vld is not set, there is no APB activity, and Hrvalid is not pulsed.
- FSM states: ST_IDLE, ST_SETUP, ST_ACCESS.
  - ST_IDLE, pend_vld=1 -> ST_SETUP. At that edge: Pselx<=sel, Pwrite/Paddr/Pwdata loaded from pending, Penable<=0, pend_vld<=0.
  - ST_SETUP -> ST_ACCESS unconditionally. At that edge Penable<=1; other APB outputs hold.
  - ST_ACCESS, pend_vld=1 -> ST_SETUP, loading the next pending request exactly as from IDLE, with Penable<=0. This gives back-to-back transfers of 2 cycles each.
  - ST_ACCESS, pend_vld=0 -> ST_IDLE. At that edge Pselx<=0 and Penable<=0.
- Paddr/Pwdata/Pwrite retain their last values in ST_IDLE.
- Read capture: at the edge leaving ST_ACCESS with Pwrite=0, Hrdata<=Prdata and Hrvalid<=1. Hrvalid is 0 at all other edges.
- Latency, accept edge E0 to completion:
  - E1: SETUP begins.
  - E2: ACCESS begins.
  - E3: ACCESS ends; Hrdata is valid in the cycle after E3.
- Since Hreadyout=~pend_vld, accept and load-out never coincide on the same entry. A new request can be accepted at the same edge the controller enters ST_ACCESS.
- Hwdata is ignored for reads, and Pwdata is still loaded from pending.

Decomposition:
- Package apb_ctrl_pkg holds:
  - the state typedef (ST_IDLE, ST_SETUP, ST_ACCESS);
  - the sel constants SEL_S0=3'b001, SEL_S1=3'b010, SEL_S2=3'b100, SEL_NONE=3'b000;
  - the decode field position (bits 27:26).
- Optional sub-module apb_addr_decode: Haddr -> {sel, mapped}, purely combinational.
- The FSM and pending register stay in the top block.

Test Plan:
- Reset behaviour: hold Hreset=1 for 2 cycles mid-write (state ST_ACCESS) -> after the reset edge Pselx=0, Penable=0, Hreadyout=1, Hrvalid=0, and there is no further APB activity.
- Single write: valid=1, Hwrite=1, Haddr=32'h8000_0010, Hwdata=32'hDEAD_BEEF at E0 ->
  - E1: Pselx=001, Penable=0, Paddr=32'h8000_0010, Pwdata=32'hDEAD_BEEF, Pwrite=1.
  - E2: Penable=1.
  - E3: Pselx=0, Penable=0.
- Single read: Haddr=32'h8800_0004, Hwrite=0 -> Pselx=100 at E1, Penable=1 at E2. With Prdata=32'd25 during ACCESS: Hrdata=32'd25 and Hrvalid=1 for exactly one cycle after E3.
- Back-to-back: a write to 32'h8400_0000 then a read to 32'h8000_0008, with valid held high -> the second request is accepted at E2. Sequence is SETUP(010), ACCESS, SETUP(001), ACCESS with no IDLE gap. Hreadyout=0 exactly in cycles with pend_vld=1.
- Unmapped: Haddr=32'h8C00_0000, valid=1 -> accepted (Hreadyout stays 1), Pselx remains 0, Penable remains 0, no Hrvalid pulse.
